clk_enable_gen: RTL and testbench
=================================

// Module: clk_enable_gen
// PURPOSE
//  Parametrised slow-clock generator for the processor core.
//  Divides the board clock into a square-wave core clock. Supports two preset
//  rates, a runtime-loaded rate and a manual single-step mode.
//  Halt freezes the output high, on a clean edge, after the last rising edge.
//  Also issues a one-cycle tick on every rising edge for debug/LED logic.
// PARAMETERS
//  CNT_W      26        width of half-period counter and divisor registers
//  DIV_SLOW   25000000  half-period terminal count, mode 0
//  DIV_FAST   250000    half-period terminal count, mode 1
//  STEP_HALF  250000    low-phase terminal count of one manual step, mode 3
// PORTS
//  clk       in   1      board clock; all logic on posedge
//  reset     in   1      reset, synchronous, active-high
//  mode      in   2      0 slow, 1 fast, 2 loaded divisor, 3 manual step
//  div_load  in   1      1-cycle strobe: capture div_in into runtime divisor
//  div_in    in   CNT_W  runtime half-period terminal count (mode 2)
//  halt      in   1      level; request to freeze the output high
//  step_req  in   1      1-cycle strobe: one manual clock pulse (mode 3)
//  clk_out   out  1      generated core clock (registered)
//  tick      out  1      1-cycle pulse, asserted in the cycle clk_out first reads 1
//  halted    out  1      1 while frozen by halt
// BEHAVIOUR
//  Reset: clk_out=0, tick=0, halted=0, count=0, state=RUN.
//   Runtime divisor = DIV_FAST; cur_div = divisor selected by mode.
//  Reset has priority over all inputs in any state, including mid-step.
//  Divisor semantics: count runs 0..cur_div, so one half period is
//   cur_div+1 clk cycles and a full period is 2*(cur_div+1).
//  div_load: next cycle, runtime divisor = div_in. A value of 0 is stored as 1.
//  cur_div reloads from the mode-selected source only when clk_out toggles.
//   A rate or mode change never shortens or stretches the current half period.
//  tick: registered. High exactly 1 cycle, coincident with the first cycle clk_out=1.
//  States: RUN, HALTED, STEP_IDLE, STEP_LOW.
//  RUN: count++ each cycle. When count==cur_div:
//   - count<=0, clk_out<=~clk_out, cur_div reloads.
//   - If the toggle is rising and halt=1: next state HALTED, halted<=1.
//   - Else if the toggle is rising and mode==3: next state STEP_IDLE.
//   - Halt during the low phase lets the low phase finish. The output rises
//     (with tick), then freezes.
//  HALTED: clk_out held 1, count held 0, halted=1.
//   - halt=0: next state RUN, halted<=0. The falling edge comes cur_div+1
//     cycles after the exit.
//   - mode changes while HALTED apply on exit.
//  STEP_IDLE: clk_out held 1, count 0.
//   - mode!=3: next state RUN.
//   - Else step_req=1: clk_out<=0, count<=0, next state STEP_LOW.
//  STEP_LOW: count++.
//   - When count==STEP_HALF: clk_out<=1, tick, next state STEP_IDLE.
//   - step_req is ignored here.
//   - A mode change is deferred until the step completes.
//  halt is ignored in STEP_IDLE/STEP_LOW; halted stays 0 there.
//  No other inputs affect outputs. div_in is sampled only on div_load.
// TESTING (bench params: DIV_SLOW=9, DIV_FAST=3, STEP_HALF=2)
//  1 Reset, mode=0 -> clk_out rises 10 cycles after reset release, period 20;
//    tick 1 cycle wide, every 20 cycles, aligned with each rise.
//  2 mode 0->1 at count=4 of a low half -> that half still lasts 10 cycles;
//    all later halves last 4 cycles.
//  3 mode=2, div_load with div_in=0 -> half period 2 cycles. Then load 5 ->
//    new rate starts only at the next toggle, 6 cycles per half.
//  4 mode=1, halt raised while low -> out rises with tick, holds 1, halted=1
//    for 20+ cycles. Drop halt -> halted=0 next cycle; out falls 4 cycles later.
//  5 mode=3 -> out settles high in STEP_IDLE. step_req -> out=0 next cycle,
//    out=1 plus tick 3 cycles later. A step_req during the low phase is ignored
//    (exactly one pulse).
//  6 reset asserted mid-STEP_LOW, and again mid-HALTED -> next cycle
//    clk_out=0, halted=0, tick=0; free-running resumes per test 1.

Source files
------------

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: square-wave core clock divider with preset, loaded and single-step rates plus halt
//   clk       in   1      board clock, all logic on posedge
//   reset     in   1      synchronous active-high reset
//   mode      in   2      0 slow, 1 fast, 2 loaded divisor, 3 manual step
//   div_load  in   1      strobe: capture div_in as the runtime divisor (0 stored as 1)
//   div_in    in   CNT_W  runtime half-period terminal count
//   halt      in   1      level: freeze clk_out high after the next rising edge
//   step_req  in   1      strobe: one manual clock pulse while idle in mode 3
//   clk_out   out  1      generated core clock (registered)
//   tick      out  1      one-cycle pulse in the first cycle clk_out reads 1
//   halted    out  1      high while frozen by halt
module clk_enable_gen #(
    parameter int CNT_W     = 26,
    parameter int DIV_SLOW  = 25000000,
    parameter int DIV_FAST  = 250000,
    parameter int STEP_HALF = 250000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    input  logic             halt,
    input  logic             step_req,
    output logic             clk_out,
    output logic             tick,
    output logic             halted
);
    typedef enum logic [1:0] {RUN, HALTED, STEP_IDLE, STEP_LOW} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] count, count_n, cur_div, div_n, rt_div, sel_div;
    logic wrap, rise, clk_n, tick_n, halted_n;
    assign sel_div = mode == 2'd0 ? CNT_W'(DIV_SLOW) :
                     mode == 2'd1 ? CNT_W'(DIV_FAST) :
                     mode == 2'd2 ? rt_div : CNT_W'(STEP_HALF);
    // the step low phase has its own terminal count, independent of cur_div
    assign wrap = state == STEP_LOW ? count == CNT_W'(STEP_HALF) : count == cur_div;
    assign rise = state == RUN && wrap && !clk_out;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            count   <= '0;
            cur_div <= mode == 2'd2 ? CNT_W'(DIV_FAST) : sel_div;
            rt_div  <= CNT_W'(DIV_FAST);
            clk_out <= 1'b0;
            tick    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            cur_div <= div_n;
            rt_div  <= div_load ? (div_in == '0 ? CNT_W'(1) : div_in) : rt_div;
            clk_out <= clk_n;
            tick    <= tick_n;
            halted  <= halted_n;
        end
    end
    // cur_div only reloads on a toggle or when re-entering RUN, so a rate change
    // never alters a half period already in progress
    always_comb begin
        state_n = state;
        count_n = count;
        div_n   = cur_div;
        case (state)
            RUN: begin
                count_n = wrap ? '0 : count + 1'b1;
                div_n   = wrap ? sel_div : cur_div;
                state_n = rise && halt ? HALTED : rise && mode == 2'd3 ? STEP_IDLE : RUN;
            end
            HALTED: begin
                count_n = '0;
                div_n   = halt ? cur_div : sel_div;
                state_n = halt ? HALTED : RUN;
            end
            STEP_IDLE: begin
                count_n = '0;
                div_n   = mode != 2'd3 ? sel_div : cur_div;
                state_n = mode != 2'd3 ? RUN : step_req ? STEP_LOW : STEP_IDLE;
            end
            STEP_LOW: begin
                count_n = wrap ? '0 : count + 1'b1;
                state_n = wrap ? STEP_IDLE : STEP_LOW;
            end
            default: state_n = RUN;
        endcase
    end
    always_comb begin
        clk_n    = state == RUN       ? clk_out ^ wrap :
                   state == STEP_IDLE ? !(mode == 2'd3 && step_req) :
                   state == STEP_LOW  ? wrap : 1'b1;
        tick_n   = rise || (state == STEP_LOW && wrap);
        halted_n = state == RUN ? rise && halt : state == HALTED ? halt : 1'b0;
    end
endmodule

// File: tb/tb_clk_enable_gen.sv
// tb_clk_enable_gen: directed checks of clk_enable_gen rates, rate changes, halt, step and reset
module tb_clk_enable_gen;
    localparam int W = 8;
    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic       load;
        logic [W-1:0] din;
        logic       halt;
        int         n;
        logic       e_clk;
        logic       e_tick;
        logic       e_halted;
    } vec_t;
    logic clk = 1'b0;
    logic reset, div_load, halt, step_req, clk_out, tick, halted;
    logic [1:0] mode;
    logic [W-1:0] div_in;
    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];
    always #5 clk = ~clk;
    clk_enable_gen #(.CNT_W(W), .DIV_SLOW(9), .DIV_FAST(3), .STEP_HALF(2)) dut (
        .clk(clk), .reset(reset), .mode(mode), .div_load(div_load), .div_in(div_in),
        .halt(halt), .step_req(step_req), .clk_out(clk_out), .tick(tick), .halted(halted)
    );
    function automatic vec_t mk(logic r, logic [1:0] m, logic l, logic [W-1:0] d, logic h,
                                int n, logic c, logic t, logic hd);
        vec_t v;
        v.rst = r; v.mode = m; v.load = l; v.din = d; v.halt = h;
        v.n = n; v.e_clk = c; v.e_tick = t; v.e_halted = hd;
        return v;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask
    task automatic chk3(input string name, input logic c, input logic t, input logic h);
        chk({name, " clk_out"}, 32'(clk_out), 32'(c));
        chk({name, " tick"}, 32'(tick), 32'(t));
        chk({name, " halted"}, 32'(halted), 32'(h));
    endtask
    task automatic wait_tick(input string name, input int exp);
        int n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 100);
        chk(name, n, exp);
    endtask
    initial begin
        int n;
        int falls;
        reset = 1'b1; mode = 2'd0; div_load = 1'b0; div_in = '0; halt = 1'b0; step_req = 1'b0;
        // reset, then free-running slow rate
        tbl.push_back(mk(1, 0, 0, 0, 0,  2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  9, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  8, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0));
        // slow -> fast mid low half: that half keeps 10 cycles
        tbl.push_back(mk(0, 0, 0, 0, 0,  4, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  5, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  3, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 1, 0));
        // loaded divisor 0 (stored as 1), then 5 from the next toggle
        tbl.push_back(mk(0, 2, 1, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0,  2, 1, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0,  2, 1, 1, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0,  2, 0, 0, 0));
        tbl.push_back(mk(0, 2, 1, 5, 0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0,  1, 1, 1, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0,  5, 1, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0,  5, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0,  1, 1, 1, 0));
        // fast rate, halt raised while low, held, then released
        tbl.push_back(mk(0, 1, 0, 0, 0,  6, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1,  3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1,  1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 20, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  3, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 0));
        foreach (tbl[i]) begin
            reset = tbl[i].rst; mode = tbl[i].mode; div_load = tbl[i].load;
            div_in = tbl[i].din; halt = tbl[i].halt;
            repeat (tbl[i].n) step();
            chk3($sformatf("v%0d", i), tbl[i].e_clk, tbl[i].e_tick, tbl[i].e_halted);
        end
        div_load = 1'b0;
        // manual step: settle high, one pulse, mid-low request ignored
        mode = 2'd3;
        n = 0;
        while (clk_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("t5 settle cycles", n, 4);
        chk3("t5 settle", 1, 1, 0);
        repeat (5) step();
        chk3("t5 idle", 1, 0, 0);
        step_req = 1'b1; step(); step_req = 1'b0;
        chk3("t5 step low", 0, 0, 0);
        step_req = 1'b1; step(); step_req = 1'b0;
        chk3("t5 ignored req", 0, 0, 0);
        step();
        chk3("t5 still low", 0, 0, 0);
        step();
        chk3("t5 step rise", 1, 1, 0);
        falls = 0;
        repeat (10) begin
            step();
            if (clk_out !== 1'b1) falls++;
        end
        chk("t5 one pulse", falls, 0);
        // reset in the middle of a step low phase
        step_req = 1'b1; step(); step_req = 1'b0;
        chk3("t6a in step", 0, 0, 0);
        step();
        reset = 1'b1; mode = 2'd0; step();
        chk3("t6a reset", 0, 0, 0);
        reset = 1'b0;
        wait_tick("t6a first rise", 10);
        wait_tick("t6a period", 20);
        step();
        chk3("t6a tick width", 1, 0, 0);
        // reset while halted
        mode = 2'd1; halt = 1'b1;
        n = 0;
        while (halted !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk3("t6b halted", 1, 1, 1);
        repeat (3) step();
        reset = 1'b1; halt = 1'b0; mode = 2'd0; step();
        chk3("t6b reset", 0, 0, 0);
        reset = 1'b0;
        wait_tick("t6b first rise", 10);
        wait_tick("t6b period", 20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
